kernel_fetch_sequencer: RTL and testbench

Parametrised kernel-weight fetch engine between the banked kernel weight BRAMs and the per-bank kernel conv FIFOs. Walks filter-group / channel / row / col over a configured filter range, issues one shared read address per cycle to BANK_NUM banks, and realigns read data after a fixed READ_LATENCY. Pushes lane-masked words downstream under credit-based flow control, with no almost-full guard band. Partial filter groups, abort and a completion pulse are supported.

---
 rtl/kernel_fetch_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_kernel_fetch_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_fetch_sequencer.sv
// kernel_fetch_sequencer
// Walks filter-group / channel / row / col over a configured filter range and
// issues one shared read address per cycle to BANK_NUM kernel weight banks.
// The read data is realigned after READ_LATENCY cycles and pushed to the
// per-bank conv FIFOs as lane-masked words under credit-based flow control.
// Optional feature: define KERNEL_FETCH_STALL_CNT_EN to add o_stall_count,
// a saturating count of RUN cycles with i_enable high and no credits.
module kernel_fetch_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int BANK_NUM      = 4,
  parameter int FILTER_WIDTH  = 8,
  parameter int CHANNEL_WIDTH = 8,
  parameter int ROW_WIDTH     = 2,
  parameter int COL_WIDTH     = 2,
  parameter int ADDR_WIDTH    = 11,
  parameter int READ_LATENCY  = 2,
  parameter int CREDIT_NUM    = 16
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [FILTER_WIDTH-1:0]        i_start_filter,
  input  logic [FILTER_WIDTH-1:0]        i_end_filter,
  input  logic [CHANNEL_WIDTH-1:0]       i_channels,
  input  logic [ROW_WIDTH-1:0]           i_rows,
  input  logic [COL_WIDTH-1:0]           i_cols,
  input  logic [ADDR_WIDTH-1:0]          i_base_address,
  input  logic                           i_credit_return,
  output logic                           o_bram_renable,
  output logic [ADDR_WIDTH-1:0]          o_bram_raddress,
  input  logic [DATA_WIDTH*BANK_NUM-1:0] i_bram_rdata,
  output logic                           o_push_valid,
  output logic [DATA_WIDTH*BANK_NUM-1:0] o_push_data,
  output logic [BANK_NUM-1:0]            o_push_lane_mask,
  output logic                           o_push_group_last,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_cfg_error,
  output logic                           o_credit_error
`ifdef KERNEL_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]                    o_stall_count
`endif
);

  localparam int CREDIT_WIDTH = $clog2(CREDIT_NUM + 1);
  localparam int FX = FILTER_WIDTH + 1;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int SW = CREDIT_WIDTH + 2;
  localparam logic [FILTER_WIDTH-1:0] BANK_F      = FILTER_WIDTH'(BANK_NUM);
  localparam logic [FX-1:0]           BANK_X      = FX'(BANK_NUM);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_NUM);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  // latched configuration
  logic [FILTER_WIDTH-1:0]  end_q;
  logic [CHANNEL_WIDTH-1:0] chan_q;
  logic [ROW_WIDTH-1:0]     row_q;
  logic [COL_WIDTH-1:0]     col_q;

  // walk counters
  logic [FILTER_WIDTH-1:0]  group_q;
  logic [CHANNEL_WIDTH-1:0] ch_cnt;
  logic [ROW_WIDTH-1:0]     row_cnt;
  logic [COL_WIDTH-1:0]     col_cnt;
  logic [ADDR_WIDTH-1:0]    addr_q;

  logic [CREDIT_WIDTH-1:0]  credits_q, credits_nxt;
  logic [SW-1:0]            credit_sum;
  logic                     credit_err_q, cfg_err_q;

  // read-latency pipeline, aligned with i_bram_rdata
  logic [READ_LATENCY-1:0]  vld_p;
  logic [READ_LATENCY-1:0]  last_p;
  logic [BANK_NUM-1:0]      mask_p [READ_LATENCY];

  logic                     cfg_ok, start_req, start_ok, cfg_bad;
  logic                     issue, ret_ok;
  logic                     col_last, row_last, ch_last, elem_last, group_final;
  logic [BANK_NUM-1:0]      lane_mask;
  logic                     early_pend;
  logic [LW-1:0]            inflight;

  assign cfg_ok = (i_channels != '0) && (i_rows != '0) && (i_cols != '0) &&
                  (i_start_filter <= i_end_filter) &&
                  ((i_start_filter % BANK_F) == '0);
  assign start_req = (state == IDLE) && i_start && i_enable && !i_abort;
  assign start_ok  = start_req && cfg_ok;
  assign cfg_bad   = start_req && !cfg_ok;

  assign col_last    = (col_cnt == (col_q - 1'b1));
  assign row_last    = (row_cnt == (row_q - 1'b1));
  assign ch_last     = (ch_cnt == (chan_q - 1'b1));
  assign elem_last   = col_last && row_last && ch_last;
  // one bit wider so a group near the top of the filter range cannot wrap
  assign group_final = ({1'b0, group_q} + BANK_X) > {1'b0, end_q};

  // lane b is live while its filter index stays inside the configured range
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < BANK_NUM; b++)
      lane_mask[b] = ({1'b0, group_q} + FX'(b)) <= {1'b0, end_q};
  end

  // words still travelling before the final stage (final stage pushes this cycle)
  always_comb begin
    early_pend = 1'b0;
    inflight   = '0;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      early_pend = early_pend | vld_p[i];
      inflight   = inflight + LW'(vld_p[i]);
    end
  end

  // next-state and issue decision; abort overrides everything
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN: begin
        issue = i_enable && (credits_q != '0);
        if (issue && elem_last && group_final) state_nxt = DRAIN;
      end
      DRAIN: if (!early_pend) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_abort) begin
      state_nxt = IDLE;
      issue     = 1'b0;
    end
  end

  // a return at full credits only counts when an issue consumes one the same cycle
  assign ret_ok      = i_credit_return && ((credits_q != CREDIT_FULL) || issue);
  assign credit_sum  = SW'(credits_q) - SW'(issue) + SW'(ret_ok) +
                       (i_abort ? SW'(inflight) : SW'(0));
  assign credits_nxt = (credit_sum > SW'(CREDIT_NUM)) ? CREDIT_FULL
                                                       : credit_sum[CREDIT_WIDTH-1:0];

  // state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // configuration latch; only consulted while a walk is active
  always_ff @(posedge i_clock) begin
    if (start_ok) begin
      end_q  <= i_end_filter;
      chan_q <= i_channels;
      row_q  <= i_rows;
      col_q  <= i_cols;
    end
  end

  // walk counters: col fastest, then row, channel, filter group
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      group_q <= '0;
      ch_cnt  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      addr_q  <= '0;
    end else if (start_ok) begin
      group_q <= i_start_filter;
      ch_cnt  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      addr_q  <= i_base_address;
    end else if (issue) begin
      addr_q <= addr_q + 1'b1;
      if (col_last) begin
        col_cnt <= '0;
        if (row_last) begin
          row_cnt <= '0;
          if (ch_last) begin
            ch_cnt  <= '0;
            group_q <= group_q + BANK_F;
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
          end
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // credit counter and error flags
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      credits_q    <= CREDIT_FULL;
      credit_err_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      credits_q    <= credits_nxt;
      credit_err_q <= credit_err_q |
                      (i_credit_return && (credits_q == CREDIT_FULL) && !issue);
      cfg_err_q    <= cfg_bad;
    end
  end

  // stage 0..READ_LATENCY-1: valid shift, flushed on abort
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_p <= '0;
    end else if (i_abort) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // stage 0..READ_LATENCY-1: lane mask and group-last travel with the valid
  always_ff @(posedge i_clock) begin
    mask_p[0] <= lane_mask;
    last_p[0] <= elem_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      mask_p[i] <= mask_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  // final stage: masked lanes carry zero
  always_comb begin
    o_push_data = '0;
    for (int b = 0; b < BANK_NUM; b++)
      if (vld_p[READ_LATENCY-1] && mask_p[READ_LATENCY-1][b])
        o_push_data[b*DATA_WIDTH +: DATA_WIDTH] = i_bram_rdata[b*DATA_WIDTH +: DATA_WIDTH];
  end

  assign o_push_valid      = vld_p[READ_LATENCY-1];
  assign o_push_lane_mask  = vld_p[READ_LATENCY-1] ? mask_p[READ_LATENCY-1] : '0;
  assign o_push_group_last = vld_p[READ_LATENCY-1] && last_p[READ_LATENCY-1];
  assign o_bram_renable    = issue;
  assign o_bram_raddress   = addr_q;
  assign o_busy            = (state != IDLE);
  assign o_done            = (state == DONE);
  assign o_cfg_error       = cfg_err_q;
  assign o_credit_error    = credit_err_q;

`ifdef KERNEL_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // credit-starved RUN cycles, saturating
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      stall_cnt <= '0;
    else if (start_ok)
      stall_cnt <= '0;
    else if ((state == RUN) && i_enable && (credits_q == '0) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign o_stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_kernel_fetch_sequencer.sv
// tb_kernel_fetch_sequencer
// Directed and randomized stimulus for kernel_fetch_sequencer with a banked
// BRAM model and a queue-based reference of the expected issue/push stream.
module tb_kernel_fetch_sequencer;
  localparam int DW = 32, BN = 4, FW = 8, CW = 8, RW = 2, COLW = 2;
  localparam int AW = 11, RL = 2, CN = 16;

  logic clk = 1'b0;
  logic i_reset, i_enable, i_start, i_abort, i_credit_return;
  logic [FW-1:0] i_start_filter, i_end_filter;
  logic [CW-1:0] i_channels;
  logic [RW-1:0] i_rows;
  logic [COLW-1:0] i_cols;
  logic [AW-1:0] i_base_address;
  logic o_bram_renable, o_push_valid, o_push_group_last;
  logic o_busy, o_done, o_cfg_error, o_credit_error;
  logic [AW-1:0] o_bram_raddress;
  logic [DW*BN-1:0] i_bram_rdata, o_push_data;
  logic [BN-1:0] o_push_lane_mask;
`ifdef KERNEL_FETCH_STALL_CNT_EN
  logic [31:0] o_stall_count;
`endif

  always #5 clk = ~clk;

  kernel_fetch_sequencer #(
    .DATA_WIDTH(DW), .BANK_NUM(BN), .FILTER_WIDTH(FW), .CHANNEL_WIDTH(CW),
    .ROW_WIDTH(RW), .COL_WIDTH(COLW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
    .CREDIT_NUM(CN)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
    .i_abort(i_abort), .i_start_filter(i_start_filter), .i_end_filter(i_end_filter),
    .i_channels(i_channels), .i_rows(i_rows), .i_cols(i_cols),
    .i_base_address(i_base_address), .i_credit_return(i_credit_return),
    .o_bram_renable(o_bram_renable), .o_bram_raddress(o_bram_raddress),
    .i_bram_rdata(i_bram_rdata), .o_push_valid(o_push_valid),
    .o_push_data(o_push_data), .o_push_lane_mask(o_push_lane_mask),
    .o_push_group_last(o_push_group_last), .o_busy(o_busy), .o_done(o_done),
    .o_cfg_error(o_cfg_error), .o_credit_error(o_credit_error)
`ifdef KERNEL_FETCH_STALL_CNT_EN
    , .o_stall_count(o_stall_count)
`endif
  );

  // BRAM model: every bank returns a word tagged with its bank and address
  function automatic logic [DW-1:0] word(int b, logic [AW-1:0] a);
    return {8'(b + 1), 8'hA5, 5'd0, a};
  endfunction

  logic [AW-1:0] hist [RL];
  always @(posedge clk) begin
    hist[0] <= o_bram_raddress;
    for (int i = 1; i < RL; i++) hist[i] <= hist[i-1];
  end
  always_comb begin
    i_bram_rdata = '0;
    for (int b = 0; b < BN; b++) i_bram_rdata[b*DW +: DW] = word(b, hist[RL-1]);
  end

  typedef struct {
    logic [DW*BN-1:0] data;
    logic [BN-1:0]    mask;
    logic             last;
  } push_t;

  push_t         exp_push[$];
  logic [AW-1:0] exp_iss[$];
  int total = 0, bad = 0;
  int cyc = 0, n_iss, n_push, n_last, exp_total;
  int first_iss, last_iss, first_push, last_push, last_flag, done_cyc;
  int outstanding = 0;  // credits consumed and not yet given back
  int held = 0;         // words the consumer holds and may return

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: groups of BN filters, each a channel*row*col block of
  // consecutive addresses starting at base.
  task automatic build(int s, int e, int ch, int r, int c, int base);
    int idx = 0;
    push_t p;
    exp_iss.delete();
    exp_push.delete();
    for (int g = s; g <= e; g += BN)
      for (int k = 0; k < ch * r * c; k++) begin
        logic [AW-1:0] a;
        a = AW'(base + idx);
        exp_iss.push_back(a);
        p.data = '0;
        p.mask = '0;
        for (int b = 0; b < BN; b++)
          if (g + b <= e) begin
            p.mask[b] = 1'b1;
            p.data[b*DW +: DW] = word(b, a);
          end
        p.last = (k == ch * r * c - 1);
        exp_push.push_back(p);
        idx++;
      end
    exp_total = exp_iss.size();
  endtask

  // One clock cycle: observe outputs mid-cycle, update the model, advance.
  task automatic tick();
    push_t p;
    bit iss, psh, ret_acc;
    @(negedge clk);
    iss = o_bram_renable;
    psh = o_push_valid;
    if (iss) begin
      check("issue_credit", outstanding < CN, 1'b1);
      check("issue_expected", exp_iss.size() > 0, 1'b1);
      if (exp_iss.size() > 0) check("issue_addr", o_bram_raddress, exp_iss.pop_front());
      if (first_iss < 0) first_iss = cyc;
      last_iss = cyc;
      n_iss++;
    end
    if (psh) begin
      check("push_expected", exp_push.size() > 0, 1'b1);
      if (exp_push.size() > 0) begin
        p = exp_push.pop_front();
        check("push_data", o_push_data, p.data);
        check("push_mask", o_push_lane_mask, p.mask);
        check("push_last", o_push_group_last, p.last);
      end
      if (o_push_group_last) begin
        n_last++;
        last_flag = cyc;
      end
      if (first_push < 0) first_push = cyc;
      last_push = cyc;
      n_push++;
    end
    if (o_done) done_cyc = cyc;
    ret_acc = i_credit_return && (outstanding > 0 || iss);
    outstanding = outstanding + (iss ? 1 : 0) - (ret_acc ? 1 : 0);
    if (i_credit_return && held > 0) held--;
    if (psh) held++;
    if (i_abort && o_busy) begin
      outstanding = outstanding - (n_iss - n_push);
      exp_iss.delete();
      exp_push.delete();
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_run(int s, int e, int ch, int r, int c, int base);
    build(s, e, ch, r, c, base);
    i_start_filter = FW'(s);
    i_end_filter = FW'(e);
    i_channels = CW'(ch);
    i_rows = RW'(r);
    i_cols = COLW'(c);
    i_base_address = AW'(base);
    n_iss = 0; n_push = 0; n_last = 0;
    first_iss = -1; last_iss = -1; first_push = -1; last_push = -1;
    last_flag = -1; done_cyc = -1;
    cyc = 0;
    i_enable = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_until_done(int budget, bit rnd);
    for (int k = 0; k < budget && done_cyc < 0; k++) begin
      i_enable = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      i_credit_return = rnd && (held > 0) && ($urandom_range(0, 1) == 1);
      tick();
    end
    i_credit_return = 1'b0;
    i_enable = 1'b1;
    check("done_seen", done_cyc >= 0, 1'b1);
    check("issue_count", n_iss, exp_total);
    check("push_count", n_push, exp_total);
    check("push_queue_empty", exp_push.size(), 0);
  endtask

  task automatic drain_credits();
    while (held > 0) begin
      i_credit_return = 1'b1;
      tick();
    end
    i_credit_return = 1'b0;
  endtask

  task automatic sc1();
    start_run(0, 3, 1, 3, 3, 'h010);
    run_until_done(40, 1'b0);
    check("s1_first_issue", first_iss, 1);
    check("s1_last_issue", last_iss, 9);
    check("s1_first_push", first_push, 3);
    check("s1_last_push", last_push, 11);
    check("s1_group_last", last_flag, 11);
    check("s1_done", done_cyc, 12);
    check("s1_idle", o_busy, 1'b0);
  endtask

  task automatic cfg_case(string tag, int s, int e, int ch, int r, int c);
    i_start_filter = FW'(s);
    i_end_filter = FW'(e);
    i_channels = CW'(ch);
    i_rows = RW'(r);
    i_cols = COLW'(c);
    i_enable = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check({tag, "_pulse"}, o_cfg_error, 1'b1);
    check({tag, "_busy"}, o_busy, 1'b0);
    tick();
    check({tag, "_clear"}, o_cfg_error, 1'b0);
    check({tag, "_busy2"}, o_busy, 1'b0);
  endtask

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_credit_return = 1'b0; i_start_filter = '0; i_end_filter = '0;
    i_channels = '0; i_rows = '0; i_cols = '0; i_base_address = '0;
    n_iss = 0; n_push = 0; n_last = 0; exp_total = 0; done_cyc = -1;
    first_iss = -1; last_iss = -1; first_push = -1; last_push = -1; last_flag = -1;
    #1;
    check("rst_renable", o_bram_renable, 1'b0);
    check("rst_addr", o_bram_raddress, 0);
    check("rst_push", o_push_valid, 1'b0);
    check("rst_data", o_push_data, 0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_credit_err", o_credit_error, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b1;
    tick();

    // basic single group
    sc1();
    drain_credits();

    // partial second group, random enable and returns
    start_run(0, 5, 2, 3, 3, $urandom_range(0, 2047));
    run_until_done(600, 1'b1);
    check("s2_group_lasts", n_last, 2);
    drain_credits();

    // random valid configurations, some bases near address wrap
    for (int t = 0; t < 4; t++) begin
      int s, base;
      s = BN * $urandom_range(0, 3);
      base = (t % 2 == 0) ? $urandom_range(2016, 2047) : $urandom_range(0, 2047);
      start_run(s, s + $urandom_range(0, 9), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(1, 3), base);
      run_until_done(1500, 1'b1);
      drain_credits();
    end

    // credit exhaustion, single return, back-to-back issue+return
    start_run(0, 11, 1, 3, 3, 0);
    repeat (25) tick();
    check("cr_stall_at_full_use", n_iss, CN);
    begin
      int rc;
      rc = cyc;
      i_credit_return = 1'b1;
      tick();
      i_credit_return = 1'b0;
      repeat (3) tick();
      check("cr_one_more", n_iss, CN + 1);
      check("cr_one_more_cycle", last_iss, rc + 1);
    end
    i_credit_return = 1'b1;
    repeat (5) tick();
    i_credit_return = 1'b0;
    repeat (4) tick();
    check("cr_steady", n_iss, CN + 6);
    run_until_done(400, 1'b1);
    drain_credits();

    // abort in cycle 5 of the basic run
    start_run(0, 3, 1, 3, 3, 'h010);
    while (cyc < 5) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("ab_idle", o_busy, 1'b0);
    repeat (10) tick();
    check("ab_pushes", n_push, 3);
    check("ab_no_late_push", last_push <= 6, 1'b1);
    check("ab_no_done", done_cyc < 0, 1'b1);
    // only the pushed words remain charged against the credits
    start_run(0, 7, 1, 3, 3, 0);
    repeat (30) tick();
    check("ab_credit_restore", n_iss, CN - 3);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    repeat (3) tick();
    drain_credits();

    // configuration errors
    cfg_case("cfg_cols0", 0, 3, 1, 3, 0);
    cfg_case("cfg_unaligned", 2, 7, 1, 1, 1);
    cfg_case("cfg_order", 8, 4, 1, 1, 1);

    // surplus return at full credits
    check("cerr_before", o_credit_error, 1'b0);
    i_credit_return = 1'b1;
    tick();
    i_credit_return = 1'b0;
    repeat (3) tick();
    check("cerr_sticky", o_credit_error, 1'b1);

    // asynchronous reset mid-run, then a clean rerun
    start_run(0, 3, 1, 3, 3, 'h010);
    while (cyc < 4) tick();
    #2;
    i_reset = 1'b0;
    #1;
    check("mrst_renable", o_bram_renable, 1'b0);
    check("mrst_addr", o_bram_raddress, 0);
    check("mrst_push", o_push_valid, 1'b0);
    check("mrst_busy", o_busy, 1'b0);
    check("mrst_credit_err", o_credit_error, 1'b0);
    outstanding = 0;
    held = 0;
    exp_iss.delete();
    exp_push.delete();
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    repeat (2) tick();
    sc1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
